// File: rtl/tpu_mac_pkg.sv
// Shared types and defaults for the operand loader and the MAC array.
package tpu_mac_pkg;

    localparam int DATA_W_DEF       = 8;
    localparam int A_DEPTH_DEF      = 16;
    localparam int W_DEPTH_DEF      = 32;
    localparam int W_LOAD_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    // True when lo <= v < hi; widened to int so range checks stay width-agnostic.
    function automatic logic in_range(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/operand_buffer_loader_if.sv
// Feature and weight byte-stream handshakes into the operand loader.
interface operand_buffer_loader_if
    import tpu_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;

    modport master (
        output a_valid, a_data, w_valid, w_data,
        input  a_ready, w_ready
    );

    modport slave (
        input  a_valid, a_data, w_valid, w_data,
        output a_ready, w_ready
    );

endinterface

// File: rtl/loader_channel.sv
// One load channel: saturating fill counter, ready logic, memory with an
// optional side write port and a registered read port.
module loader_channel
    import tpu_mac_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int DEPTH     = A_DEPTH_DEF,
    parameter  int MEM_DEPTH = DEPTH,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hold,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              accept,
    output logic [CW-1:0]     count,
    output logic              full_next,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign ready     = !hold && (count < CW'(DEPTH));
    assign accept    = valid && ready;
    // Full after the coming edge; lets the FSM jump straight to READY.
    assign full_next = (count == CW'(DEPTH)) || (accept && (count == CW'(DEPTH - 1)));

    // Fill counter: restarts on rst/clear, otherwise steps on each accept.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (accept) begin
            count <= count + CW'(1);
        end
    end

    // Memory write: stream data at the fill pointer, or a side-port write.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            if (accept) begin
                mem[AW'(count)] <= data;
            end else if (ext_we) begin
                mem[ext_addr] <= ext_data;
            end
        end
    end

    // Registered read; out-of-range addresses return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (in_range(32'(rd_addr), 0, MEM_DEPTH)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/operand_buffer_loader.sv
// Loads feature and weight operand memories, then accepts MAC results
// into the upper region of the weight memory.
module operand_buffer_loader
    import tpu_mac_pkg::*;
#(
    parameter  int DATA_W       = DATA_W_DEF,
    parameter  int A_DEPTH      = A_DEPTH_DEF,
    parameter  int W_DEPTH      = W_DEPTH_DEF,
    parameter  int W_LOAD_DEPTH = W_LOAD_DEPTH_DEF,
    localparam int A_AW         = $clog2(A_DEPTH),
    localparam int W_AW         = $clog2(W_DEPTH),
    localparam int A_CW         = $clog2(A_DEPTH + 1),
    localparam int W_CW         = $clog2(W_LOAD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    operand_buffer_loader_if.slave   bus,
    input  logic                     res_we,
    input  logic [W_AW-1:0]          res_addr,
    input  logic [DATA_W-1:0]        res_data,
    input  logic [A_AW-1:0]          rd_a_addr,
    output logic [DATA_W-1:0]        rd_a_data,
    input  logic [W_AW-1:0]          rd_w_addr,
    output logic [DATA_W-1:0]        rd_w_data,
    output logic [A_AW:0]            a_count,
    output logic [W_CW-1:0]          w_count,
    output logic                     loaded,
    output logic                     err
);

    state_t            state;
    logic              a_accept, w_accept;
    logic              a_full_next, w_full_next;
    logic [A_CW-1:0]   a_cnt;
    logic              res_ok;

    assign res_ok  = res_we && (state == READY) &&
                     in_range(32'(res_addr), W_LOAD_DEPTH, W_DEPTH);
    assign a_count = (A_AW + 1)'(a_cnt);

    loader_channel #(
        .DATA_W    (DATA_W),
        .DEPTH     (A_DEPTH),
        .MEM_DEPTH (A_DEPTH)
    ) u_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hold      (state == READY),
        .valid     (bus.a_valid),
        .data      (bus.a_data),
        .ready     (bus.a_ready),
        .accept    (a_accept),
        .count     (a_cnt),
        .full_next (a_full_next),
        .ext_we    (1'b0),
        .ext_addr  ('0),
        .ext_data  ('0),
        .rd_addr   (rd_a_addr),
        .rd_data   (rd_a_data)
    );

    loader_channel #(
        .DATA_W    (DATA_W),
        .DEPTH     (W_LOAD_DEPTH),
        .MEM_DEPTH (W_DEPTH)
    ) u_w (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hold      (state == READY),
        .valid     (bus.w_valid),
        .data      (bus.w_data),
        .ready     (bus.w_ready),
        .accept    (w_accept),
        .count     (w_count),
        .full_next (w_full_next),
        .ext_we    (res_ok),
        .ext_addr  (res_addr),
        .ext_data  (res_data),
        .rd_addr   (rd_w_addr),
        .rd_data   (rd_w_data)
    );

    // Load-sequence FSM with registered loaded flag and sticky result error.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state  <= IDLE;
            loaded <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (res_we && !res_ok) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (a_accept || w_accept) begin
                        if (a_full_next && w_full_next) begin
                            state  <= READY;
                            loaded <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (a_full_next && w_full_next) begin
                        state  <= READY;
                        loaded <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state  <= IDLE;
                    loaded <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_buffer_loader.sv
module tb_operand_buffer_loader;

  localparam int K_ARDY   = 0;
  localparam int K_WRDY   = 1;
  localparam int K_LOADED = 2;
  localparam int K_ERR    = 3;
  localparam int K_ACNT   = 4;
  localparam int K_WCNT   = 5;
  localparam int K_RDA    = 6;
  localparam int K_RDW    = 7;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       res_we;
  logic [4:0] res_addr;
  logic [7:0] res_data;
  logic [3:0] rd_a_addr;
  logic [7:0] rd_a_data;
  logic [4:0] rd_w_addr;
  logic [7:0] rd_w_data;
  logic [4:0] a_count;
  logic [4:0] w_count;
  logic       loaded;
  logic       err;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  operand_buffer_loader_if #(.DATA_W(8)) bus ();

  operand_buffer_loader #(
    .DATA_W       (8),
    .A_DEPTH      (16),
    .W_DEPTH      (32),
    .W_LOAD_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .rd_a_addr (rd_a_addr),
    .rd_a_data (rd_a_data),
    .rd_w_addr (rd_w_addr),
    .rd_w_data (rd_w_data),
    .a_count   (a_count),
    .w_count   (w_count),
    .loaded    (loaded),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_ARDY:   return "a_ready";
      K_WRDY:   return "w_ready";
      K_LOADED: return "loaded";
      K_ERR:    return "err";
      K_ACNT:   return "a_count";
      K_WCNT:   return "w_count";
      K_RDA:    return "rd_a_data";
      default:  return "rd_w_data";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_ARDY:   return {31'b0, bus.a_ready};
      K_WRDY:   return {31'b0, bus.w_ready};
      K_LOADED: return {31'b0, loaded};
      K_ERR:    return {31'b0, err};
      K_ACNT:   return {27'b0, a_count};
      K_WCNT:   return {27'b0, w_count};
      K_RDA:    return {24'b0, rd_a_data};
      default:  return {24'b0, rd_w_data};
    endcase
  endfunction

  task automatic chk(input int k, input int v);
    item_t it;
    it.kind = k;
    it.exp  = 32'(v);
    q.push_back(it);
  endtask

  task automatic chk8(input int k, input int v);
    chk(k, v & 255);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t       it;
      logic [31:0] act;
      it  = q.pop_front();
      act = sample(it.kind);
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t",
                 kname(it.kind), act, it.exp, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.w_valid = 1'b0; bus.w_data = '0;
    res_we = 1'b0; res_addr = '0; res_data = '0;
    rd_a_addr = '0; rd_w_addr = '0;
    step(); step();
    chk(K_ACNT, 0); chk(K_WCNT, 0); chk(K_LOADED, 0); chk(K_ERR, 0);
    chk(K_RDA, 0);  chk(K_RDW, 0);
    rst = 1'b0;
    step();
    chk(K_ARDY, 1); chk(K_WRDY, 1);
    n_tests++;
    if (bus.a_ready !== 1'b1 || bus.w_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready after reset: a_ready=%b w_ready=%b", bus.a_ready, bus.w_ready);
    end
    n_tests++;
    if (a_count !== 5'd0 || w_count !== 5'd0) begin
      n_fail++;
      $display("FAIL counts after reset: a_count=%0d w_count=%0d", a_count, w_count);
    end

    bus.a_valid = 1'b1; bus.w_valid = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.a_data = 8'(i + 1);
      bus.w_data = 8'(-(i + 1));
      chk(K_ACNT, int'(i)); chk(K_WCNT, int'(i));
      chk(K_ARDY, 1); chk(K_WRDY, 1); chk(K_LOADED, 0);
      step();
    end
    chk(K_ACNT, 16); chk(K_WCNT, 16);
    chk(K_ARDY, 0);  chk(K_WRDY, 0); chk(K_LOADED, 1);
    n_tests++;
    if (loaded !== 1'b1 || bus.a_ready !== 1'b0 || bus.w_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL after full load: loaded=%b a_ready=%b w_ready=%b",
               loaded, bus.a_ready, bus.w_ready);
    end
    bus.a_data = 8'h99; bus.w_data = 8'h99;
    step(); step();
    chk(K_ACNT, 16); chk(K_WCNT, 16); chk(K_LOADED, 1);
    bus.a_valid = 1'b0; bus.w_valid = 1'b0;
    rd_a_addr = 4'd3; rd_w_addr = 5'd15;
    step();
    chk8(K_RDA, 4); chk8(K_RDW, -16);

    res_we = 1'b1; res_addr = 5'd20; res_data = 8'h7F; rd_w_addr = 5'd20;
    step();
    res_we = 1'b0;
    step();
    chk8(K_RDW, 8'h7F); chk(K_ERR, 0);
    n_tests++;
    if (rd_w_data !== 8'h7F || err !== 1'b0) begin
      n_fail++;
      $display("FAIL result write: rd_w_data=%0h err=%b", rd_w_data, err);
    end
    res_we = 1'b1; res_data = 8'h11;
    step();
    chk8(K_RDW, 8'h7F);
    res_we = 1'b0;
    step();
    chk8(K_RDW, 8'h11);
    res_we = 1'b1; res_addr = 5'd16; res_data = 8'h22; rd_w_addr = 5'd16;
    step();
    res_we = 1'b0;
    step();
    chk8(K_RDW, 8'h22); chk(K_ERR, 0);
    res_we = 1'b1; res_addr = 5'd5; res_data = 8'h55; rd_w_addr = 5'd5;
    step();
    res_we = 1'b0;
    chk(K_ERR, 1);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal result write: err=%b", err);
    end
    step();
    chk8(K_RDW, -6); chk(K_ERR, 1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk(K_ERR, 0); chk(K_LOADED, 0); chk(K_ACNT, 0); chk(K_WCNT, 0);
    chk(K_ARDY, 1); chk(K_WRDY, 1);
    bus.a_valid = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      bus.a_data = 8'(8'h41 + i);
      step();
    end
    bus.a_valid = 1'b0;
    chk(K_ACNT, 7); chk(K_LOADED, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    rd_a_addr = 4'd2;
    chk(K_ACNT, 0); chk(K_ARDY, 1);
    step();
    chk8(K_RDA, 8'h43);
    bus.a_valid = 1'b1; bus.a_data = 8'h55;
    step();
    bus.a_valid = 1'b0;
    chk(K_ACNT, 1);
    rd_a_addr = 4'd0;
    step();
    chk8(K_RDA, 8'h55);
    bus.a_valid = 1'b1; bus.a_data = 8'h66; clear = 1'b1;
    chk(K_ARDY, 1);
    step();
    bus.a_valid = 1'b0; clear = 1'b0;
    chk(K_ACNT, 0);
    step();
    chk8(K_RDA, 8'h55);

    bus.w_valid = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.w_data = 8'(8'h10 + i);
      step();
    end
    bus.w_valid = 1'b0;
    chk(K_WCNT, 16); chk(K_WRDY, 0); chk(K_ARDY, 1); chk(K_LOADED, 0);
    res_we = 1'b1; res_addr = 5'd20; res_data = 8'h33; rd_w_addr = 5'd20;
    step();
    res_we = 1'b0;
    chk(K_ERR, 1);
    step();
    chk8(K_RDW, 8'h11);
    rd_w_addr = 5'd4;
    bus.a_valid = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.a_data = 8'(i);
      chk(K_LOADED, 0);
      step();
    end
    bus.a_valid = 1'b0;
    chk(K_LOADED, 1); chk(K_ACNT, 16); chk(K_ARDY, 0); chk(K_ERR, 1);
    chk8(K_RDW, 8'h14);
    rd_a_addr = 4'd15;
    step();
    chk8(K_RDA, 15);

    rst = 1'b1;
    step();
    chk(K_ERR, 0); chk(K_ACNT, 0); chk(K_WCNT, 0); chk(K_LOADED, 0);
    chk(K_RDA, 0); chk(K_RDW, 0);
    rst = 1'b0;
    step();
    chk(K_ARDY, 1); chk(K_WRDY, 1);
    step(); step();

    if (q.size() != 0 || n_fail != 0) begin
      $display("FAIL %0d pending, %0d failed", q.size(), n_fail);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_buffer_loader.md
Name: operand_buffer_loader

Overview:
- Parametrised successor to the feature/weight memory loader.
- Accepts feature (A) and weight (W) byte streams over valid/ready handshakes and fills a feature memory and the lower (operand) region of a weight memory.
- Signals when both regions are loaded, then accepts MAC results into the upper (result) region of the weight memory.
- Exposes one registered read port per memory to the downstream MAC array.

Parameters:
- DATA_W, 8, signed element width in bits.
- A_DEPTH, 16, feature memory entries.
- W_DEPTH, 32, total weight memory entries.
- W_LOAD_DEPTH, 16, entries loaded from the W stream; entries W_LOAD_DEPTH..W_DEPTH-1 are the result region. Must satisfy 0 < W_LOAD_DEPTH < W_DEPTH.
- Derived: A_AW = $clog2(A_DEPTH), W_AW = $clog2(W_DEPTH).

Ports:
- clk  in  1  Single clock for the block.
- rst  in  1  Reset: synchronous to clk, active-high.
- clear  in  1  Synchronous restart of a load sequence; memory contents are kept.
- a_valid  in  1  Feature element valid.
- a_data  in  DATA_W  Feature element (signed).
- a_ready  out  1  Feature element accepted this cycle when a_valid && a_ready.
- w_valid  in  1  Weight element valid.
- w_data  in  DATA_W  Weight element (signed).
- w_ready  out  1  Weight element accepted this cycle when w_valid && w_ready.
- res_we  in  1  Result write strobe.
- res_addr  in  W_AW  Result address in absolute weight-memory addressing.
- res_data  in  DATA_W  Result value.
- rd_a_addr  in  A_AW  Feature read address.
- rd_a_data  out  DATA_W  Feature read data.
- rd_w_addr  in  W_AW  Weight read address.
- rd_w_data  out  DATA_W  Weight read data.
- a_count  out  A_AW+1  Number of feature elements written.
- w_count  out  $clog2(W_LOAD_DEPTH+1)  Number of weight elements written.
- loaded  out  1  High while in READY.
- err  out  1  Sticky flag for an illegal result write.

Behaviour:
- FSM states and transitions:
  - IDLE → LOAD on the first accepted A or W element.
  - LOAD → READY in the cycle after the final element is accepted, i.e. when a_count == A_DEPTH and w_count == W_LOAD_DEPTH.
  - READY → IDLE on clear.
  - If both regions fill in the same cycle that the first element is accepted (depth-1 configurations), IDLE goes directly to READY.
- Handshake readiness:
  - a_ready = (state != READY) && (a_count < A_DEPTH).
  - w_ready = (state != READY) && (w_count < W_LOAD_DEPTH).
  - Readiness is combinational from registered state; it does not depend on a_valid/w_valid.
- Write on accept:
  - An accepted A element is written to Feature_Memory[a_count], and a_count increments in the same clock edge. W behaves the same way into Weight_Memory[w_count].
  - A and W accept independently; simultaneous accepts are both taken.
  - A full channel stalls (ready low) while the other channel continues.
  - Counters saturate at their depth. They never wrap.
- Result writes:
  - Honoured only when state == READY and W_LOAD_DEPTH <= res_addr < W_DEPTH.
  - Any other res_we is dropped, memory is unchanged, and err is set.
  - err clears only on rst or clear.
- Read ports:
  - 1-cycle latency: rd_x_data <= mem[rd_x_addr] at each posedge.
  - A feature address >= A_DEPTH returns 0.
  - Read-during-write to the same address returns the old data.
- clear:
  - Takes effect at the next edge from any state: counts go to 0, state goes to IDLE, err goes to 0.
  - Memories are not erased.
  - clear has priority over accepts and result writes in the same cycle; ready is still high that cycle, but the data is discarded.
- rst:
  - Same effect as clear; in addition rd_a_data and rd_w_data go to 0.
  - Reset mid-load abandons the partial load.
- Reset values: a_count=0, w_count=0, loaded=0, err=0, rd_a_data=0, rd_w_data=0, state=IDLE. Hence a_ready=1 and w_ready=1 one cycle after reset is released.
- Arithmetic: data is stored as-is with no sign extension; widths match exactly.

Decomposition:
- Shared package (tpu_mac_pkg):
  - Default DATA_W.
  - FSM state enumeration: IDLE=2'd0, LOAD=2'd1, READY=2'd2.
  - Default depths A_DEPTH and W_DEPTH, shared with the MAC array.
- One sub-module, loader_channel:
  - Parameters DATA_W and DEPTH.
  - Contains the saturating write counter, the ready logic and the memory with its registered read port.
  - Instantiated for A and for W.
- The top level adds the FSM, the result-write path into the W memory and err.

Test Plan:
- Reset then stream A=1..16 and W=-1..-16, valid held high → a_ready/w_ready drop after the 16th accept, loaded=1 on the next cycle, rd_a_addr=3 gives 4, rd_w_addr=15 gives -16 one cycle later.
- W stream only (16 elements), A idle → state LOAD, w_ready=0, a_ready=1, loaded=0; then 16 A elements → loaded=1.
- In READY: res_we at addr 20 with 0x7F, then rd_w_addr=20 → reads 0x7F, err=0. Next, res_we at addr 5 → Weight_Memory[5] unchanged, err=1.
- clear after 7 A accepts → a_count=0, state IDLE, rd_a_addr=2 still returns the old value 3, next accept writes address 0.
- res_we asserted during LOAD → dropped, err=1; rst → err=0, both rd_data=0, both counts 0.
- Valid asserted while loaded=1 → no accept, counts stay 16/16.
